// File: rtl/rr_arbiter_8.sv
// Eight-requester round-robin arbiter with registered one-hot grant, per-owner hold
// limit and a forced-release pulse; every ownership change passes through IDLE.
module rr_arbiter_8 #(
    parameter int MAX_HOLD = 16,
    parameter int HOLD_W   = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_vld,
    output logic       preempt
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_SAT   = '1;
    localparam logic [HOLD_W-1:0] HOLD_ONE   = HOLD_W'(1);

    state_t            state, state_n;
    logic [2:0]        ptr, ptr_n;
    logic [2:0]        idx_n;
    logic [2:0]        winner, cand;
    logic              found;
    logic [HOLD_W-1:0] hold_cnt, hold_n;
    logic              hold_expired;
    logic [7:0]        gnt_n;
    logic              preempt_n;

    // Rotating priority scan: the first set request at or after ptr wins.
    always_comb begin
        found  = 1'b0;
        winner = ptr;
        cand   = ptr;
        for (int i = 0; i < 8; i++) begin
            cand = ptr + 3'(i);
            if (!found && req[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    assign hold_expired = (MAX_HOLD != 0) && (hold_cnt == HOLD_LIMIT);

    // NOTE: every output of this block gets a default before the case so no latch is inferred.
    always_comb begin
        state_n   = state;
        ptr_n     = ptr;
        idx_n     = gnt_idx;
        hold_n    = hold_cnt;
        gnt_n     = gnt;
        preempt_n = 1'b0;
        case (state)
            IDLE: begin
                gnt_n = '0;
                if (en && found) begin
                    state_n = GRANT;
                    idx_n   = winner;
                    ptr_n   = winner + 3'd1;
                    hold_n  = HOLD_ONE;
                    gnt_n   = 8'h01 << winner;
                end
            end
            GRANT: begin
                // Release causes are prioritised: disable, then owner drop, then hold expiry.
                if (!en) begin
                    state_n   = IDLE;
                    gnt_n     = '0;
                    preempt_n = 1'b1;
                end else if (!req[gnt_idx]) begin
                    state_n = IDLE;
                    gnt_n   = '0;
                end else if (hold_expired) begin
                    state_n   = IDLE;
                    gnt_n     = '0;
                    preempt_n = 1'b1;
                end else if (hold_cnt != HOLD_SAT) begin
                    hold_n = hold_cnt + HOLD_ONE;
                end
            end
            default: begin
                state_n = IDLE;
                gnt_n   = '0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= 3'd0;
            gnt_idx  <= 3'd0;
            hold_cnt <= '0;
            gnt      <= 8'h00;
            preempt  <= 1'b0;
        end else begin
            state    <= state_n;
            ptr      <= ptr_n;
            gnt_idx  <= idx_n;
            hold_cnt <= hold_n;
            gnt      <= gnt_n;
            preempt  <= preempt_n;
        end
    end

    assign gnt_vld = (state == GRANT);

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Directed bench for rr_arbiter_8: three instances (hold limit 16, 1, 4) share clock,
// reset and enable; each output bundle is compared against hand-derived values.
module tb_rr_arbiter_8;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [7:0] req_a, req_b, req_c;

    logic [7:0] gnt_a, gnt_b, gnt_c;
    logic [2:0] idx_a, idx_b, idx_c;
    logic       vld_a, vld_b, vld_c;
    logic       pre_a, pre_b, pre_c;

    int n_cmp = 0;
    int n_err = 0;

    rr_arbiter_8 #(.MAX_HOLD(16), .HOLD_W(5)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .req(req_a),
        .gnt(gnt_a), .gnt_idx(idx_a), .gnt_vld(vld_a), .preempt(pre_a)
    );

    rr_arbiter_8 #(.MAX_HOLD(1), .HOLD_W(5)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .req(req_b),
        .gnt(gnt_b), .gnt_idx(idx_b), .gnt_vld(vld_b), .preempt(pre_b)
    );

    rr_arbiter_8 #(.MAX_HOLD(4), .HOLD_W(5)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .en(en), .req(req_c),
        .gnt(gnt_c), .gnt_idx(idx_c), .gnt_vld(vld_c), .preempt(pre_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] pk(input logic [7:0] g, input logic [2:0] i,
                                       input logic v, input logic p);
        return {3'b000, g, i, v, p};
    endfunction

    // Fields packed as {gnt, gnt_idx, gnt_vld, preempt}.
    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %04h expected %04h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        en    = 1'b1;
        req_a = 8'h00;
        req_b = 8'h00;
        req_c = 8'h00;

        // Reset state
        tick();
        check("reset_a", pk(gnt_a, idx_a, vld_a, pre_a), pk(8'h00, 3'd0, 1'b0, 1'b0));
        check("reset_bc", {gnt_b, gnt_c}, 16'h0000);
        rst_n = 1'b1;
        tick();
        check("idle_after_reset", pk(gnt_a, idx_a, vld_a, pre_a), pk(8'h00, 3'd0, 1'b0, 1'b0));

        // Single request and normal release (A, ptr 0 -> 4)
        req_a = 8'h08;
        tick();
        check("single_grant", pk(gnt_a, idx_a, vld_a, pre_a), pk(8'h08, 3'd3, 1'b1, 1'b0));
        req_a = 8'h00;
        tick();
        check("single_release", pk(gnt_a, idx_a, vld_a, pre_a), pk(8'h00, 3'd3, 1'b0, 1'b0));

        // Rotation with wrap (B, MAX_HOLD=1): 0..7,0 each separated by a preempt IDLE
        req_b = 8'hFF;
        for (int i = 0; i < 9; i++) begin
            tick();
            check($sformatf("rot_grant%0d", i), pk(gnt_b, idx_b, vld_b, pre_b),
                  pk(8'(1 << (i % 8)), 3'(i % 8), 1'b1, 1'b0));
            tick();
            check($sformatf("rot_idle%0d", i), pk(gnt_b, idx_b, vld_b, pre_b),
                  pk(8'h00, 3'(i % 8), 1'b0, 1'b1));
        end
        req_b = 8'h00;
        tick();
        check("rot_quiet", pk(gnt_b, idx_b, vld_b, pre_b), pk(8'h00, 3'd0, 1'b0, 1'b0));

        // Priority pointer (A): owner 6 moves ptr to 7, so 0x41 picks bit 0
        req_a = 8'h40;
        tick();
        check("ptr_grant6", pk(gnt_a, idx_a, vld_a, pre_a), pk(8'h40, 3'd6, 1'b1, 1'b0));
        req_a = 8'h00;
        tick();
        check("ptr_release6", pk(gnt_a, idx_a, vld_a, pre_a), pk(8'h00, 3'd6, 1'b0, 1'b0));
        req_a = 8'h41;
        tick();
        check("ptr_pick0", pk(gnt_a, idx_a, vld_a, pre_a), pk(8'h01, 3'd0, 1'b1, 1'b0));
        req_a = 8'h00;
        tick();

        // Hold limit (C, MAX_HOLD=4): requester 1 holds 4 cycles, then 5 wins
        req_c = 8'h22;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("hold_cyc%0d", i), pk(gnt_c, idx_c, vld_c, pre_c),
                  pk(8'h02, 3'd1, 1'b1, 1'b0));
        end
        tick();
        check("hold_preempt", pk(gnt_c, idx_c, vld_c, pre_c), pk(8'h00, 3'd1, 1'b0, 1'b1));
        tick();
        check("hold_next5", pk(gnt_c, idx_c, vld_c, pre_c), pk(8'h20, 3'd5, 1'b1, 1'b0));
        req_c = 8'h00;
        tick();

        // Hold expiry coinciding with owner release (C, ptr 6 -> owner 1)
        req_c = 8'h02;
        tick();
        check("exp_rel_grant", pk(gnt_c, idx_c, vld_c, pre_c), pk(8'h02, 3'd1, 1'b1, 1'b0));
        tick();
        tick();
        tick();
        req_c = 8'h00;
        tick();
        check("exp_rel_nopre", pk(gnt_c, idx_c, vld_c, pre_c), pk(8'h00, 3'd1, 1'b0, 1'b0));

        // Enable revoke (A, ptr 1): owner 2, en low, no grants, then ptr 3 wins
        req_a = 8'h04;
        tick();
        check("en_owner2", pk(gnt_a, idx_a, vld_a, pre_a), pk(8'h04, 3'd2, 1'b1, 1'b0));
        en = 1'b0;
        tick();
        check("en_revoke", pk(gnt_a, idx_a, vld_a, pre_a), pk(8'h00, 3'd2, 1'b0, 1'b1));
        req_a = 8'hFF;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("en_off%0d", i), pk(gnt_a, idx_a, vld_a, pre_a),
                  pk(8'h00, 3'd2, 1'b0, 1'b0));
        end
        en = 1'b1;
        tick();
        check("en_resume3", pk(gnt_a, idx_a, vld_a, pre_a), pk(8'h08, 3'd3, 1'b1, 1'b0));

        // Async reset mid-grant (A): move ownership to 7 first
        req_a = 8'h80;
        tick();
        check("to7_release", pk(gnt_a, idx_a, vld_a, pre_a), pk(8'h00, 3'd3, 1'b0, 1'b0));
        tick();
        check("owner7", pk(gnt_a, idx_a, vld_a, pre_a), pk(8'h80, 3'd7, 1'b1, 1'b0));
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", pk(gnt_a, idx_a, vld_a, pre_a), pk(8'h00, 3'd0, 1'b0, 1'b0));
        tick();
        check("reset_hold_nopre", pk(gnt_a, idx_a, vld_a, pre_a), pk(8'h00, 3'd0, 1'b0, 1'b0));
        rst_n = 1'b1;
        tick();
        check("after_reset7", pk(gnt_a, idx_a, vld_a, pre_a), pk(8'h80, 3'd7, 1'b1, 1'b0));

        // Owner release and en drop on the same edge counts as a forced release
        req_a = 8'h00;
        en    = 1'b0;
        tick();
        check("rel_en_drop", pk(gnt_a, idx_a, vld_a, pre_a), pk(8'h00, 3'd7, 1'b0, 1'b1));
        en = 1'b1;
        tick();
        check("pulse_single", pk(gnt_a, idx_a, vld_a, pre_a), pk(8'h00, 3'd7, 1'b0, 1'b0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
